// File: rtl/riscv_core_vector_pkg.sv
// rtl/riscv_core_vector_pkg.sv - shared constants, state encoding and lane-mask helper for the vector sequencer
package riscv_core_vector_pkg;

    localparam int NLANES = 4;
    localparam int VLMAX  = 64;
    localparam int REG_W  = 5;
    localparam int IDX_W  = 6;
    localparam int VL_W   = 7;
    localparam int GRP_W  = IDX_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Lane i of group grp is live iff its element index 4*grp+i is below vl.
    function automatic logic [NLANES-1:0] lane_mask(input logic [GRP_W-1:0] grp,
                                                     input logic [VL_W-1:0]  vl);
        lane_mask = '0;
        for (int i = 0; i < NLANES; i++) begin
            lane_mask[i] = (({1'b0, grp, 2'b00} + VL_W'(i)) < vl);
        end
    endfunction

endpackage

// File: rtl/riscv_core_vector_wb_pipe.sv
// rtl/riscv_core_vector_wb_pipe.sv - LAT-deep stall-frozen writeback delay line (valid, index, lane mask)
module riscv_core_vector_wb_pipe
    import riscv_core_vector_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv_i,
    input  logic              valid_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [NLANES-1:0] mask_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [NLANES-1:0] mask_o
);

    logic [LAT-1:0]    valid_q;
    logic [IDX_W-1:0]  idx_q  [LAT];
    logic [NLANES-1:0] mask_q [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                idx_q[s]  <= '0;
                mask_q[s] <= '0;
            end
        end else if (adv_i) begin
            valid_q[0] <= valid_i;
            idx_q[0]   <= idx_i;
            mask_q[0]  <= mask_i;
            for (int s = 1; s < LAT; s++) begin
                valid_q[s] <= valid_q[s-1];
                idx_q[s]   <= idx_q[s-1];
                mask_q[s]  <= mask_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign idx_o   = idx_q[LAT-1];
    assign mask_o  = mask_q[LAT-1];

endmodule

// File: rtl/riscv_core_vector_sequencer.sv
// rtl/riscv_core_vector_sequencer.sv - splits a vector op into aligned 4-element read groups and masked writebacks
module riscv_core_vector_sequencer #(
    parameter int LAT   = 2,
    parameter int VLMAX = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_val,
    output logic       req_rdy,
    input  logic [4:0] req_vd,
    input  logic [4:0] req_vs1,
    input  logic [4:0] req_vs2,
    input  logic [6:0] req_vl,
    input  logic       stall,
    output logic       rd_val,
    output logic [4:0] raddr0,
    output logic [4:0] raddr1,
    output logic [5:0] ridx0,
    output logic [5:0] ridx1,
    output logic       wen_p_0,
    output logic       wen_p_1,
    output logic       wen_p_2,
    output logic       wen_p_3,
    output logic [4:0] waddr_p,
    output logic [5:0] widx_p,
    output logic       busy,
    output logic       done
);
    import riscv_core_vector_pkg::NLANES, riscv_core_vector_pkg::IDX_W,
           riscv_core_vector_pkg::VL_W, riscv_core_vector_pkg::GRP_W,
           riscv_core_vector_pkg::seq_state_e, riscv_core_vector_pkg::ST_IDLE,
           riscv_core_vector_pkg::ST_ISSUE, riscv_core_vector_pkg::ST_DRAIN,
           riscv_core_vector_pkg::lane_mask;

    localparam logic [VL_W-1:0] VL_CAP = VL_W'(VLMAX);

    seq_state_e        state_q, state_d;
    logic [4:0]        vd_q, vs1_q, vs2_q;
    logic [VL_W-1:0]   vl_q;
    logic [GRP_W-1:0]  grp_q, last_grp_q;
    logic              zero_done_q;

    logic [VL_W-1:0]   eff_vl;
    logic [GRP_W-1:0]  last_grp;
    logic              accept, issue_fire, last_issue;
    logic              wb_valid, wb_fire, last_wb;
    logic [IDX_W-1:0]  wb_idx;
    logic [NLANES-1:0] wb_mask;

    assign eff_vl     = (req_vl > VL_CAP) ? VL_CAP : req_vl;
    assign last_grp   = GRP_W'((eff_vl - VL_W'(1)) >> 2);
    assign accept     = req_val && req_rdy;
    assign issue_fire = (state_q == ST_ISSUE) && !stall;
    assign last_issue = issue_fire && (grp_q == last_grp_q);
    assign wb_fire    = wb_valid && !stall;
    // Only one op is in flight, so the last group is recognised by its index.
    assign last_wb    = wb_fire && (state_q == ST_DRAIN) && (wb_idx == {last_grp_q, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept && (eff_vl != '0)) state_d = ST_ISSUE;
            ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (last_wb) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_rdy = (state_q == ST_IDLE) && !reset;
        busy    = (state_q != ST_IDLE);
        rd_val  = issue_fire;
        {wen_p_3, wen_p_2, wen_p_1, wen_p_0} = wb_fire ? wb_mask : '0;
        done    = zero_done_q || last_wb;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vd_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vl_q        <= '0;
            grp_q       <= '0;
            last_grp_q  <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= accept && (eff_vl == '0);
            if (accept) begin
                vd_q       <= req_vd;
                vs1_q      <= req_vs1;
                vs2_q      <= req_vs2;
                vl_q       <= eff_vl;
                grp_q      <= '0;
                last_grp_q <= last_grp;
            end else if (issue_fire && !last_issue) begin
                grp_q <= grp_q + GRP_W'(1);
            end
        end
    end

    riscv_core_vector_wb_pipe #(.LAT(LAT)) u_wb_pipe (
        .clk     (clk),
        .reset   (reset),
        .adv_i   (!stall),
        .valid_i (issue_fire),
        .idx_i   ({grp_q, 2'b00}),
        .mask_i  (lane_mask(grp_q, vl_q)),
        .valid_o (wb_valid),
        .idx_o   (wb_idx),
        .mask_o  (wb_mask)
    );

    assign raddr0  = vs1_q;
    assign raddr1  = vs2_q;
    assign ridx0   = {grp_q, 2'b00};
    assign ridx1   = {grp_q, 2'b00};
    assign waddr_p = vd_q;
    assign widx_p  = wb_idx;

endmodule

// File: tb/tb_riscv_core_vector_sequencer.sv
// tb/tb_riscv_core_vector_sequencer.sv - table-driven scoreboard bench for the vector sequencer
module tb_riscv_core_vector_sequencer;

    localparam int LAT   = 2;
    localparam int VLMAX = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_val = 1'b0;
    logic       req_rdy;
    logic [4:0] req_vd = '0, req_vs1 = '0, req_vs2 = '0;
    logic [6:0] req_vl = '0;
    logic       stall = 1'b0;
    logic       rd_val;
    logic [4:0] raddr0, raddr1;
    logic [5:0] ridx0, ridx1;
    logic       wen_p_0, wen_p_1, wen_p_2, wen_p_3;
    logic [4:0] waddr_p;
    logic [5:0] widx_p;
    logic       busy, done;
    logic [3:0] wen;

    riscv_core_vector_sequencer #(.LAT(LAT), .VLMAX(VLMAX)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
        .req_vd(req_vd), .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vl(req_vl),
        .stall(stall), .rd_val(rd_val), .raddr0(raddr0), .raddr1(raddr1),
        .ridx0(ridx0), .ridx1(ridx1), .wen_p_0(wen_p_0), .wen_p_1(wen_p_1),
        .wen_p_2(wen_p_2), .wen_p_3(wen_p_3), .waddr_p(waddr_p), .widx_p(widx_p),
        .busy(busy), .done(done)
    );

    assign wen = {wen_p_3, wen_p_2, wen_p_1, wen_p_0};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; int a0; int a1; int idx; } rd_exp_t;
    typedef struct { int cyc; int vd; int idx; int mask; } wb_exp_t;
    typedef struct { int vl; int off; int len; int groups; int mask; int done_off; } vec_t;

    rd_exp_t rd_q[$];
    wb_exp_t wb_q[$];
    rd_exp_t re;
    wb_exp_t we;

    int st_from = 0;
    int st_to   = 0;
    always @(posedge clk) begin
        #2;
        stall = (cyc >= st_from) && (cyc < st_to);
    end

    bit mon_en = 1'b0;
    int wr_cnt = 0;
    int done_cyc = -1;
    int done_cnt = 0;
    int last_mask = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall) begin
                chk("stall_rd_val", rd_val, 0);
                chk("stall_wen", wen, 0);
            end
            if (!busy) begin
                chk("idle_rd_val", rd_val, 0);
                chk("idle_wen", wen, 0);
            end
            if (rd_val) begin
                chk("rd_pending", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                    re = rd_q.pop_front();
                    chk("rd_cycle", cyc, re.cyc);
                    chk("raddr0", raddr0, re.a0);
                    chk("raddr1", raddr1, re.a1);
                    chk("ridx0", ridx0, re.idx);
                    chk("ridx1", ridx1, re.idx);
                end
            end
            if (wen != 4'd0) begin
                wr_cnt++;
                last_mask = int'(wen);
                chk("wb_pending", wb_q.size() > 0, 1);
                if (wb_q.size() > 0) begin
                    we = wb_q.pop_front();
                    chk("wb_cycle", cyc, we.cyc);
                    chk("waddr_p", waddr_p, we.vd);
                    chk("widx_p", widx_p, we.idx);
                    chk("wen_mask", wen, we.mask);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic run_op(input int vl, input int off, input int len,
                          input int exp_groups, input int exp_mask, input int exp_done);
        int t, eff, c, w, m, vd, a0, a1;
        vd = int'($urandom_range(0, 31));
        a0 = int'($urandom_range(0, 31));
        a1 = int'($urandom_range(0, 31));
        @(posedge clk); #1;
        t = cyc;
        st_from = t + off;
        st_to   = t + off + len;
        req_val = 1'b1;
        req_vd  = 5'(vd);
        req_vs1 = 5'(a0);
        req_vs2 = 5'(a1);
        req_vl  = 7'(vl);
        eff = (vl > VLMAX) ? VLMAX : vl;
        c = t;
        for (int k = 0; k < (eff + 3) / 4; k++) begin
            c++;
            while (c >= st_from && c < st_to) c++;
            rd_q.push_back('{c, a0, a1, 4 * k});
            w = c;
            for (int j = 0; j < LAT; j++) begin
                w++;
                while (w >= st_from && w < st_to) w++;
            end
            m = 0;
            for (int i = 0; i < 4; i++) if (4 * k + i < eff) m |= (1 << i);
            wb_q.push_back('{w, vd, 4 * k, m});
        end
        wr_cnt = 0;
        done_cyc = -1;
        last_mask = 0;
        @(negedge clk);
        chk("rdy_at_accept", req_rdy, 1);
        @(posedge clk); #1;
        if (vl > 0) begin
            req_vd  = 5'(~vd);
            req_vs1 = 5'(a0 + 1);
            req_vs2 = 5'(a1 + 3);
            req_vl  = 7'd5;
        end else begin
            req_val = 1'b0;
        end
        @(posedge clk); #1;
        req_val = 1'b0;
        for (int i = 0; i < 400 && done_cyc < 0; i++) @(posedge clk);
        #1;
        chk("done_seen", done_cyc >= 0, 1);
        chk("done_offset", done_cyc - t, exp_done);
        chk("write_count", wr_cnt, exp_groups);
        if (exp_groups > 0) chk("last_mask", last_mask, exp_mask);
        @(negedge clk);
        chk("rdy_after_done", req_rdy, 1);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);
    endtask

    vec_t tbl[10];

    initial begin
        int t, cnt0;
        tbl[0] = '{8,   0, 0,  2, 15,  4};
        tbl[1] = '{6,   0, 0,  2,  3,  4};
        tbl[2] = '{0,   0, 0,  0,  0,  1};
        tbl[3] = '{100, 0, 0, 16, 15, 18};
        tbl[4] = '{1,   0, 0,  1,  1,  3};
        tbl[5] = '{64,  0, 0, 16, 15, 18};
        tbl[6] = '{5,   0, 0,  2,  1,  4};
        tbl[7] = '{8,   2, 3,  2, 15,  7};
        tbl[8] = '{3,   0, 2,  1,  7,  4};
        tbl[9] = '{12,  3, 1,  3, 15,  6};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_rdy", req_rdy, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rd_val", rd_val, 0);
        chk("reset_wen", wen, 0);
        chk("reset_done", done, 0);
        chk("reset_raddr0", raddr0, 0);
        chk("reset_raddr1", raddr1, 0);
        chk("reset_ridx0", ridx0, 0);
        chk("reset_waddr_p", waddr_p, 0);
        chk("reset_widx_p", widx_p, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_init", req_rdy, 1);
        mon_en = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_op(tbl[v].vl, tbl[v].off, tbl[v].len, tbl[v].groups, tbl[v].mask, tbl[v].done_off);
        end

        // Abort a VL=16 op with a reset in its third cycle.
        @(posedge clk); #1;
        t = cyc;
        req_val = 1'b1;
        req_vd  = 5'd9;
        req_vs1 = 5'd10;
        req_vs2 = 5'd11;
        req_vl  = 7'd16;
        rd_q.push_back('{t + 1, 10, 11, 0});
        rd_q.push_back('{t + 2, 10, 11, 4});
        wr_cnt = 0;
        @(posedge clk); #1;
        req_val = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rdy_in_reset", req_rdy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        cnt0 = done_cnt;
        @(negedge clk);
        chk("rdy_after_reset", req_rdy, 1);
        chk("busy_after_reset", busy, 0);
        chk("rd_q_drained", rd_q.size(), 0);
        repeat (12) @(negedge clk);
        chk("no_wen_after_reset", wr_cnt, 0);
        chk("no_done_after_reset", done_cnt - cnt0, 0);

        run_op(4, 0, 0, 1, 15, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached limit %0d", $time, 500000);
        $fatal(1, "watchdog expired");
    end

endmodule
